// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing-bus width, default card colours and bundled timing type.
package vga_pkg;

  localparam int TW = 11;

  localparam logic [11:0] BACK_COLOR = 12'h0_A_A;
  localparam logic [11:0] SEL_COLOR  = 12'hF_F_0;

  typedef logic [TW-1:0] coord_t;
  typedef logic [11:0]   rgb_t;

  typedef struct packed {
    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   hblnk;
    logic   vblnk;
  } timing_t;

endpackage

// File: rtl/draw_card_grid_if.sv
// Pixel-stream bus of the card-grid overlay: incoming timing/pixel plus game state, outgoing timing/pixel.
interface draw_card_grid_if #(
  parameter int N    = 12,
  parameter int IDXW = $clog2(N)
);
  import vga_pkg::*;

  coord_t            hcount_in;
  coord_t            vcount_in;
  logic              hsync_in;
  logic              vsync_in;
  logic              hblnk_in;
  logic              vblnk_in;
  rgb_t              rgb_in;
  logic [N-1:0]      face_up;
  logic [12*N-1:0]   face_color;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_en;

  coord_t            hcount_out;
  coord_t            vcount_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              hblnk_out;
  logic              vblnk_out;
  rgb_t              rgb_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output face_up, face_color, sel_idx, sel_en,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  face_up, face_color, sel_idx, sel_en,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );

endinterface

// File: rtl/card_locator.sv
// Combinational map of a pixel coordinate to {hit, card index, border} for the card grid.
module card_locator
  import vga_pkg::*;
#(
  parameter int X_POS  = 112,
  parameter int Y_POS  = 84,
  parameter int CARD_W = 180,
  parameter int CARD_H = 140,
  parameter int GAP    = 20,
  parameter int N_COLS = 4,
  parameter int N_ROWS = 3,
  parameter int BORDER = 6,
  parameter int IDXW   = 4
) (
  input  coord_t          hcount,
  input  coord_t          vcount,
  output logic            hit,
  output logic [IDXW-1:0] idx,
  output logic            border
);

  logic [11:0]       h12;
  logic [11:0]       v12;
  logic [N_COLS-1:0] in_col;
  logic [N_COLS-1:0] edge_col;
  logic [N_ROWS-1:0] in_row;
  logic [N_ROWS-1:0] edge_row;

  // One extra bit so the far edge of the last card never wraps.
  assign h12 = {1'b0, hcount};
  assign v12 = {1'b0, vcount};

  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_col
      localparam logic [11:0] LO = 12'(X_POS + gi * (CARD_W + GAP));
      localparam logic [11:0] HI = 12'(X_POS + gi * (CARD_W + GAP) + CARD_W);
      assign in_col[gi]   = (h12 >= LO) && (h12 < HI);
      assign edge_col[gi] = (h12 < LO + 12'(BORDER)) || (h12 >= HI - 12'(BORDER));
    end
    for (gi = 0; gi < N_ROWS; gi++) begin : g_row
      localparam logic [11:0] LO = 12'(Y_POS + gi * (CARD_H + GAP));
      localparam logic [11:0] HI = 12'(Y_POS + gi * (CARD_H + GAP) + CARD_H);
      assign in_row[gi]   = (v12 >= LO) && (v12 < HI);
      assign edge_row[gi] = (v12 < LO + 12'(BORDER)) || (v12 >= HI - 12'(BORDER));
    end
  endgenerate

  always_comb begin
    int col_sel;
    int row_sel;
    col_sel = 0;
    row_sel = 0;
    for (int c = 0; c < N_COLS; c++) begin
      if (in_col[c]) col_sel = c;
    end
    for (int r = 0; r < N_ROWS; r++) begin
      if (in_row[r]) row_sel = r;
    end
    hit    = (|in_col) && (|in_row);
    border = hit && ((|(in_col & edge_col)) || (|(in_row & edge_row)));
    idx    = IDXW'(row_sel * N_COLS + col_sel);
  end

endmodule

// File: rtl/draw_card_grid.sv
// Card-grid overlay on a VGA pixel stream: face/back colours per card and a blinking selection border.
module draw_card_grid #(
  parameter int          X_POS        = 112,
  parameter int          Y_POS        = 84,
  parameter int          CARD_W       = 180,
  parameter int          CARD_H       = 140,
  parameter int          GAP          = 20,
  parameter int          N_COLS       = 4,
  parameter int          N_ROWS       = 3,
  parameter int          BORDER       = 6,
  parameter logic [11:0] BACK_COLOR   = vga_pkg::BACK_COLOR,
  parameter logic [11:0] SEL_COLOR    = vga_pkg::SEL_COLOR,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic             pclk,
  input  logic             rst,
  draw_card_grid_if.slave  bus
);
  import vga_pkg::*;

  localparam int N    = N_COLS * N_ROWS;
  localparam int IDXW = $clog2(N);
  localparam int CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDXW:0]   N_L     = (IDXW + 1)'(N);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BLINK_FRAMES - 1);

  logic            loc_hit;
  logic [IDXW-1:0] loc_idx;
  logic            loc_border;
  rgb_t            face_color_in [N];
  timing_t         timing_in;

  logic            vblnk_prev_reg;
  logic [N-1:0]    face_up_sh_reg;
  rgb_t            face_color_sh_reg [N];
  logic [IDXW-1:0] sel_idx_sh_reg;
  logic            sel_en_sh_reg;
  logic [CNTW-1:0] frame_cnt_reg;
  logic            blink_on_reg;
  logic            frame_start;
  logic            sel_valid;

  timing_t         timing_s1_reg;
  rgb_t            rgb_s1_reg;
  logic            hit_s1_reg;
  logic            border_s1_reg;
  logic            sel_s1_reg;
  logic            face_s1_reg;
  rgb_t            face_rgb_s1_reg;

  timing_t         timing_s2_reg;
  rgb_t            rgb_s2_reg;
  rgb_t            rgb_next;

  card_locator #(
    .X_POS(X_POS), .Y_POS(Y_POS), .CARD_W(CARD_W), .CARD_H(CARD_H), .GAP(GAP),
    .N_COLS(N_COLS), .N_ROWS(N_ROWS), .BORDER(BORDER), .IDXW(IDXW)
  ) u_locator (
    .hcount (bus.hcount_in),
    .vcount (bus.vcount_in),
    .hit    (loc_hit),
    .idx    (loc_idx),
    .border (loc_border)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_face
      assign face_color_in[gi] = bus.face_color[12*gi +: 12];
    end
  endgenerate

  assign timing_in   = {bus.hcount_in, bus.vcount_in, bus.hsync_in, bus.vsync_in,
                        bus.hblnk_in, bus.vblnk_in};
  assign frame_start = bus.vblnk_in && !vblnk_prev_reg;
  assign sel_valid   = sel_en_sh_reg && ({1'b0, sel_idx_sh_reg} < N_L);

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_reg <= 1'b0;
      face_up_sh_reg <= '0;
      for (int k = 0; k < N; k++) face_color_sh_reg[k] <= '0;
      sel_idx_sh_reg <= '0;
      sel_en_sh_reg  <= 1'b0;
      frame_cnt_reg  <= '0;
      blink_on_reg   <= 1'b1;
    end else begin
      vblnk_prev_reg <= bus.vblnk_in;
      if (frame_start) begin
        face_up_sh_reg <= bus.face_up;
        for (int k = 0; k < N; k++) face_color_sh_reg[k] <= face_color_in[k];
        sel_idx_sh_reg <= bus.sel_idx;
        sel_en_sh_reg  <= bus.sel_en;
        if (frame_cnt_reg == CNT_MAX) begin
          frame_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + CNTW'(1);
        end
      end
    end
  end

  // The card index is resolved against the shadows here, so a shadow swap at
  // frame start cannot change a pixel that is already in flight.
  always_ff @(posedge pclk) begin
    if (rst) begin
      timing_s1_reg   <= '0;
      rgb_s1_reg      <= '0;
      hit_s1_reg      <= 1'b0;
      border_s1_reg   <= 1'b0;
      sel_s1_reg      <= 1'b0;
      face_s1_reg     <= 1'b0;
      face_rgb_s1_reg <= '0;
    end else begin
      timing_s1_reg   <= timing_in;
      rgb_s1_reg      <= bus.rgb_in;
      hit_s1_reg      <= loc_hit;
      border_s1_reg   <= loc_border;
      sel_s1_reg      <= sel_valid && (sel_idx_sh_reg == loc_idx) && blink_on_reg;
      face_s1_reg     <= face_up_sh_reg[loc_idx];
      face_rgb_s1_reg <= face_color_sh_reg[loc_idx];
    end
  end

  always_comb begin
    rgb_next = rgb_s1_reg;
    if (sel_s1_reg && border_s1_reg) rgb_next = SEL_COLOR;
    else if (hit_s1_reg && face_s1_reg) rgb_next = face_rgb_s1_reg;
    else if (hit_s1_reg) rgb_next = BACK_COLOR;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      timing_s2_reg <= '0;
      rgb_s2_reg    <= '0;
    end else begin
      timing_s2_reg <= timing_s1_reg;
      rgb_s2_reg    <= rgb_next;
    end
  end

  assign bus.hcount_out = timing_s2_reg.hcount;
  assign bus.vcount_out = timing_s2_reg.vcount;
  assign bus.hsync_out  = timing_s2_reg.hsync;
  assign bus.vsync_out  = timing_s2_reg.vsync;
  assign bus.hblnk_out  = timing_s2_reg.hblnk;
  assign bus.vblnk_out  = timing_s2_reg.vblnk;
  assign bus.rgb_out    = rgb_s2_reg;

endmodule

// File: tb/tb_draw_card_grid.sv
// Directed self-checking bench for draw_card_grid with default geometry (4x3 cards, 30-frame blink).
module tb_draw_card_grid;

  logic pclk;
  logic rst;
  int   n_cmp;
  int   n_err;

  draw_card_grid_if #(.N(12)) bus ();

  draw_card_grid dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic set_px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.hsync_in  = h[0];
    bus.vsync_in  = v[0];
    bus.hblnk_in  = 1'b0;
    bus.rgb_in    = rgb;
  endtask

  // Drive one pixel, follow it with an idle pixel, check it exactly 2 cycles later.
  task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] rgb, input logic [11:0] exp);
    @(negedge pclk); set_px(h, v, rgb);
    @(negedge pclk); set_px(11'd0, 11'd0, 12'h000);
    @(negedge pclk);
    check_val({tag, "_rgb"}, 32'(bus.rgb_out), 32'(exp));
    check_val({tag, "_h"}, 32'(bus.hcount_out), 32'(h));
  endtask

  task automatic frame_start();
    @(negedge pclk); bus.vblnk_in = 1'b1;
    @(negedge pclk); bus.vblnk_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rgb"}, 32'(bus.rgb_out), 32'h0);
    check_val({tag, "_tim"}, 32'({bus.hcount_out, bus.vcount_out, bus.hsync_out,
                                  bus.vsync_out, bus.hblnk_out, bus.vblnk_out}), 32'h0);
  endtask

  initial begin
    logic exp_blink;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    set_px(11'd0, 11'd0, 12'h000);
    bus.vblnk_in   = 1'b0;
    bus.face_up    = '0;
    bus.face_color = '0;
    bus.sel_idx    = '0;
    bus.sel_en     = 1'b0;
    repeat (3) @(negedge pclk);
    check_zero("reset");
    check_val("reset_blink", 32'(dut.blink_on_reg), 32'h1);
    check_val("reset_cnt", 32'(dut.frame_cnt_reg), 32'h0);
    rst = 1'b0;

    // All face down, no selection
    frame_start();
    probe("back_312_244", 11'd312, 11'd244, 12'h555, 12'h0AA);
    probe("gap_300_244", 11'd300, 11'd244, 12'h555, 12'h555);
    probe("right_892_300", 11'd892, 11'd300, 12'h777, 12'h777);
    probe("left_111_300", 11'd111, 11'd300, 12'h777, 12'h777);
    probe("c11_891_543", 11'd891, 11'd543, 12'h111, 12'h0AA);

    // Mid-frame change must wait for the next frame start
    bus.face_up[5] = 1'b1;
    bus.face_color[12*5 +: 12] = 12'h80F;
    bus.face_up[11] = 1'b1;
    bus.face_color[12*11 +: 12] = 12'h3C5;
    probe("midframe_400_300", 11'd400, 11'd300, 12'h222, 12'h0AA);
    frame_start();
    probe("face5_400_300", 11'd400, 11'd300, 12'h222, 12'h80F);
    probe("face11_891_543", 11'd891, 11'd543, 12'h222, 12'h3C5);
    probe("face5_edge_312_244", 11'd312, 11'd244, 12'h222, 12'h80F);

    // Pixel coinciding with frame start keeps old shadows; next pixel sees new ones
    bus.face_up[5] = 1'b0;
    @(negedge pclk); set_px(11'd400, 11'd300, 12'h222); bus.vblnk_in = 1'b1;
    @(negedge pclk); set_px(11'd400, 11'd300, 12'h222);
    @(negedge pclk); check_val("fs_same_px", 32'(bus.rgb_out), 32'h80F);
    @(negedge pclk); check_val("fs_next_px", 32'(bus.rgb_out), 32'h0AA);
    bus.vblnk_in = 1'b0;
    set_px(11'd0, 11'd0, 12'h000);

    // Out-of-range selection draws no border
    bus.sel_en  = 1'b1;
    bus.sel_idx = 4'd13;
    frame_start();
    probe("sel13_313_300", 11'd313, 11'd300, 12'h333, 12'h0AA);
    probe("sel13_891_543", 11'd891, 11'd543, 12'h333, 12'h3C5);
    probe("sel13_312_244", 11'd312, 11'd244, 12'h333, 12'h0AA);

    // Reset mid-frame
    @(negedge pclk); set_px(11'd400, 11'd300, 12'h999); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check_zero($sformatf("midrst%0d", i));
    end
    check_val("midrst_blink", 32'(dut.blink_on_reg), 32'h1);
    check_val("midrst_cnt", 32'(dut.frame_cnt_reg), 32'h0);
    rst = 1'b0;
    set_px(11'd891, 11'd543, 12'h444);
    @(negedge pclk); set_px(11'd0, 11'd0, 12'h000);
    check_val("rel_lat1_rgb", 32'(bus.rgb_out), 32'h0);
    check_val("rel_lat1_h", 32'(bus.hcount_out), 32'h0);
    @(negedge pclk);
    check_val("rel_lat2_rgb", 32'(bus.rgb_out), 32'h0AA);
    check_val("rel_lat2_h", 32'(bus.hcount_out), 32'd891);

    // Blink: counter restarts at 0 with blink on; toggles every 30th frame start
    bus.face_up[5] = 1'b1;
    bus.sel_en  = 1'b1;
    bus.sel_idx = 4'd5;
    for (int f = 1; f <= 61; f++) begin
      frame_start();
      exp_blink = ((f / 30) % 2) == 0;
      probe($sformatf("blink_f%0d", f), 11'd313, 11'd300, 12'h666,
            exp_blink ? 12'hFF0 : 12'h80F);
      if (f % 10 == 0 || f == 1)
        probe($sformatf("inner_f%0d", f), 11'd400, 11'd300, 12'h666, 12'h80F);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
